// File: rtl/bs_mult_pkg.sv
// bs_mult_pkg: definitions shared by the bit-serial multiplier controller
// and the array top.
//   state_e  - controller FSM states (IDLE / SHIFT / DONE)
//   BS_WIDTH, BS_PIPE_LAT - default operand width and array product latency
//   cnt_w()  - width of the controller cycle counter
package bs_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int BS_WIDTH    = 8;
   localparam int BS_PIPE_LAT = 2;

   // The counter must reach 2*width+pipe_lat-1.
   function automatic int cnt_w(input int width, input int pipe_lat);
      return $clog2(2 * width + pipe_lat);
   endfunction

endpackage

// File: rtl/bs_mult_ctrl_deser.sv
// bs_deser: serial-to-parallel shift register, LSB-first stream.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (takes priority over en)
//   en         - shift din in from the MSB side
//   din        - serial input bit
//   q          - parallel contents; after W enabled shifts the first bit
//                received sits in q[0]
module bs_deser #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = {din, q_q[W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/bs_mult_ctrl.sv
// bs_mult_ctrl: operand feeder and product collector for the bit-serial
// multiplier slice array. One multiplication in flight at a time.
//   in_valid/in_ready/in_x/in_y   - operand pair handshake (unsigned)
//   ser_x/ser_y/ser_xy            - serial operand bits to the array, LSB first
//   ser_rin                       - one-cycle start token with operand bit 0
//   ser_lastbit                   - one-cycle pulse on the last stream cycle
//   prod_bit                      - serial product from the array, LSB first,
//                                   bit 0 arrives PIPE_LAT cycles after ser_rin
//   out_valid/out_ready/out_prod  - 2*WIDTH-bit product handshake
module bs_mult_ctrl
   import bs_mult_pkg::*;
#(
   parameter int WIDTH    = BS_WIDTH,
   parameter int PIPE_LAT = BS_PIPE_LAT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   output logic                 ser_x,
   output logic                 ser_y,
   output logic                 ser_xy,
   output logic                 ser_rin,
   output logic                 ser_lastbit,
   input  logic                 prod_bit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_w(WIDTH, PIPE_LAT);

   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] CNT_LAST    = CW'(PW + PIPE_LAT - 1);
   localparam logic [CW-1:0] CNT_PRE_LB  = CW'(PW - 2);
   localparam logic [CW-1:0] CNT_CAP_LO  = CW'(PIPE_LAT);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] x_sr_q, x_sr_d;
   logic [WIDTH-1:0] y_sr_q, y_sr_d;
   logic             ser_x_q, ser_x_d;
   logic             ser_y_q, ser_y_d;
   logic             ser_xy_q, ser_xy_d;
   logic             ser_rin_q, ser_rin_d;
   logic             ser_lastbit_q, ser_lastbit_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             cap_clr;
   logic             cap_en;
   logic [PW-1:0]    cap;

   // The serial outputs are registered, so each cycle computes the bit that
   // will be visible in the following cycle. On accept, operand bit 0 is
   // loaded straight into the output flops and the shift registers keep the
   // remaining bits; zeros shifted in supply the trailing zero bits.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      x_sr_d        = x_sr_q;
      y_sr_d        = y_sr_q;
      ser_x_d       = 1'b0;
      ser_y_d       = 1'b0;
      ser_xy_d      = 1'b0;
      ser_rin_d     = 1'b0;
      ser_lastbit_d = 1'b0;
      in_ready_d    = in_ready_q;
      out_valid_d   = out_valid_q;
      cap_clr       = 1'b0;
      cap_en        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d    = ST_SHIFT;
               cnt_d      = '0;
               x_sr_d     = in_x >> 1;
               y_sr_d     = in_y >> 1;
               ser_x_d    = in_x[0];
               ser_y_d    = in_y[0];
               ser_xy_d   = in_x[0] & in_y[0];
               ser_rin_d  = 1'b1;
               in_ready_d = 1'b0;
               cap_clr    = 1'b1;
            end
         end

         ST_SHIFT: begin
            cnt_d         = cnt_q + CNT_ONE;
            x_sr_d        = x_sr_q >> 1;
            y_sr_d        = y_sr_q >> 1;
            ser_x_d       = x_sr_q[0];
            ser_y_d       = y_sr_q[0];
            ser_xy_d      = x_sr_q[0] & y_sr_q[0];
            ser_lastbit_d = (cnt_q == CNT_PRE_LB);
            // Window upper bound is implicit: cnt never exceeds CNT_LAST.
            cap_en        = (cnt_q >= CNT_CAP_LO);
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         ser_x_q       <= 1'b0;
         ser_y_q       <= 1'b0;
         ser_xy_q      <= 1'b0;
         ser_rin_q     <= 1'b0;
         ser_lastbit_q <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ser_x_q       <= ser_x_d;
         ser_y_q       <= ser_y_d;
         ser_xy_q      <= ser_xy_d;
         ser_rin_q     <= ser_rin_d;
         ser_lastbit_q <= ser_lastbit_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
      end
   end

   // Operand shift registers are pure data, reloaded on every accept.
   always_ff @(posedge clk) begin
      x_sr_q <= x_sr_d;
      y_sr_q <= y_sr_d;
   end

   bs_deser #(
      .W (PW)
   ) u_cap (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cap_clr),
      .en    (cap_en),
      .din   (prod_bit),
      .q     (cap)
   );

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_prod    = cap;
   assign ser_x       = ser_x_q;
   assign ser_y       = ser_y_q;
   assign ser_xy      = ser_xy_q;
   assign ser_rin     = ser_rin_q;
   assign ser_lastbit = ser_lastbit_q;

endmodule

// File: tb/tb_bs_mult_ctrl.sv
// tb_bs_mult_ctrl: self-checking bench for bs_mult_ctrl (WIDTH=8, PIPE_LAT=2).
// A behavioral bit-serial array model returns product bits LSB-first
// PIPE_LAT cycles after ser_rin and drives prod_bit high outside its window.
module tb_bs_mult_ctrl;

   localparam int WIDTH    = 8;
   localparam int PIPE_LAT = 2;
   localparam int PW       = 2 * WIDTH;

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] p;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_x = '0;
   logic [7:0]  in_y = '0;
   logic        ser_x, ser_y, ser_xy, ser_rin, ser_lastbit;
   logic        prod_bit = 1'b1;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_prod;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   bs_mult_ctrl #(
      .WIDTH    (WIDTH),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_y        (in_y),
      .ser_x       (ser_x),
      .ser_y       (ser_y),
      .ser_xy      (ser_xy),
      .ser_rin     (ser_rin),
      .ser_lastbit (ser_lastbit),
      .prod_bit    (prod_bit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_prod    (out_prod)
   );

   // Array model: collects operand bits seen so far and emits product bit k
   // in cycle rin+PIPE_LAT+k. Bit k only depends on operand bits 0..k, which
   // have always arrived by then.
   int          m_k = 0;
   bit          m_act = 0;
   logic [7:0]  m_x = '0;
   logic [7:0]  m_y = '0;
   logic [15:0] m_p;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act    = 0;
         m_k      = 0;
         prod_bit = 1'b1;
      end else begin
         if (ser_rin) begin
            m_act = 1;
            m_k   = 0;
            m_x   = '0;
            m_y   = '0;
         end else if (m_act) begin
            m_k++;
         end
         if (m_act && m_k < WIDTH) begin
            m_x[m_k] = ser_x;
            m_y[m_k] = ser_y;
         end
         m_p = {8'h00, m_x} * {8'h00, m_y};
         if (m_act && m_k >= PIPE_LAT && m_k < PIPE_LAT + PW)
            prod_bit = m_p[m_k - PIPE_LAT];
         else
            prod_bit = 1'b1;
         if (m_act && m_k >= PIPE_LAT + PW) m_act = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Issue one operation and follow it until out_valid (or a 40-cycle bound).
   // Returns at the falling edge of the first out_valid cycle; cycle c is
   // counted from the accept cycle T.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit rdy,
                         output int lat, output int nrin, output int nlast,
                         output int lastpos, output logic [15:0] sx,
                         output logic [15:0] sxy);
      lat = -1; nrin = 0; nlast = 0; lastpos = -1; sx = '0; sxy = '0;
      @(negedge clk);
      in_x = x; in_y = y; in_valid = 1'b1; out_ready = rdy;
      chk("in_ready_before_op", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (ser_rin) nrin++;
         if (ser_lastbit) begin nlast++; lastpos = c; end
         if (c <= 16) begin sx[c-1] = ser_x; sxy[c-1] = ser_xy; end
         if (out_valid) begin lat = c; break; end
      end
   endtask

   initial begin
      static vec_t tbl[6];
      static vec_t b2b[4];
      int lat, nrin, nlast, lastpos;
      logic [15:0] sx, sxy;
      int seen, n_acc, n_res, last_d;

      tbl[0] = '{8'h03, 8'h05, 16'h000F};
      tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
      tbl[2] = '{8'h00, 8'hA5, 16'h0000};
      tbl[3] = '{8'h81, 8'h01, 16'h0081};
      tbl[4] = '{8'h12, 8'h34, 16'h03A8};
      tbl[5] = '{8'hA5, 8'h5A, 16'h3A02};

      b2b[0] = '{8'h0F, 8'h11, 16'h00FF};
      b2b[1] = '{8'h80, 8'h80, 16'h4000};
      b2b[2] = '{8'hC8, 8'h64, 16'h4E20};
      b2b[3] = '{8'h12, 8'h34, 16'h03A8};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_prod", out_prod, 0);
      chk("rst_ser_bits", {ser_x, ser_y, ser_xy, ser_rin, ser_lastbit}, 0);
      rst_n = 1'b1;

      // Table-driven single operations, out_ready held high
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].x, tbl[i].y, 1'b1, lat, nrin, nlast, lastpos, sx, sxy);
         chk($sformatf("latency[%0d]", i), lat, 19);
         chk($sformatf("prod[%0d]", i), out_prod, tbl[i].p);
         chk($sformatf("rin_count[%0d]", i), nrin, 1);
         chk($sformatf("lastbit_count[%0d]", i), nlast, 1);
         chk($sformatf("lastbit_pos[%0d]", i), lastpos, 16);
         chk($sformatf("ser_x_stream[%0d]", i), sx, {8'h00, tbl[i].x});
         chk($sformatf("ser_xy_stream[%0d]", i), sxy, {8'h00, tbl[i].x & tbl[i].y});
         @(negedge clk);
         chk($sformatf("in_ready_after[%0d]", i), in_ready, 1);
         chk($sformatf("out_valid_after[%0d]", i), out_valid, 0);
      end

      // Backpressure: result held for 10 cycles, new operands ignored
      run_op(8'hC8, 8'h64, 1'b0, lat, nrin, nlast, lastpos, sx, sxy);
      chk("bp_latency", lat, 19);
      chk("bp_prod", out_prod, 16'h4E20);
      for (int j = 0; j < 10; j++) begin
         in_valid = 1'b1; in_x = 8'h01; in_y = 8'h01;
         @(negedge clk);
         chk($sformatf("bp_out_valid[%0d]", j), out_valid, 1);
         chk($sformatf("bp_out_prod[%0d]", j), out_prod, 16'h4E20);
         chk($sformatf("bp_in_ready[%0d]", j), in_ready, 0);
         chk($sformatf("bp_no_rin[%0d]", j), ser_rin, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);

      // Reset mid-operation at cnt=5 (cycle T+6)
      in_x = 8'hFF; in_y = 8'hFF; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_in_flight", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_prod", out_prod, 0);
      chk("abort_ser_bits", {ser_x, ser_y, ser_xy, ser_rin, ser_lastbit}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int j = 0; j < 25; j++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_result", seen, 0);
      run_op(8'h07, 8'h09, 1'b1, lat, nrin, nlast, lastpos, sx, sxy);
      chk("post_reset_latency", lat, 19);
      chk("post_reset_prod", out_prod, 16'h003F);

      // Back-to-back with in_valid and out_ready held high
      @(negedge clk);
      out_ready = 1'b1;
      n_acc = 0; n_res = 0; last_d = -1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (out_valid) begin
            chk($sformatf("b2b_prod[%0d]", n_res), out_prod, b2b[n_res].p);
            if (n_res > 0) chk($sformatf("b2b_spacing[%0d]", n_res), cyc - last_d, 20);
            last_d = cyc;
            n_res++;
            if (n_res == 4) break;
         end
         if (in_ready) begin
            if (n_acc < 4) begin
               in_x = b2b[n_acc].x; in_y = b2b[n_acc].y; in_valid = 1'b1;
               n_acc++;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("b2b_result_count", n_res, 4);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
